// File: rtl/switch_deadtime.sv
// Break-before-make gate driver: turn-off takes effect on the sampling edge, turn-on after DEADTIME edges.
// Short-circuit forces all gates off into a sticky FAULT. No backpressure; Sin is sampled every cycle.
module switch_deadtime #(
  parameter int DEADTIME = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] Sin,
  input  logic       Short,
  input  logic       clr_fault,
  output logic [5:0] gate,
  output logic       busy,
  output logic       fault,
  output logic       illegal
);

  typedef enum logic [1:0] {IDLE, BREAK, FAULT} state_t;

  localparam logic [7:0] CNT_LOAD = 8'(DEADTIME - 1);

  state_t     state, state_nxt;
  logic [5:0] target, target_nxt, gate_nxt, s_legal;
  logic [7:0] cnt, cnt_nxt;
  logic       fault_nxt, illegal_nxt, sin_bad;
  logic [2:0] pair_on;

  // More than one active pair would short a leg, so such a request means "all off".
  assign pair_on = {|Sin[5:4], |Sin[3:2], |Sin[1:0]};
  assign sin_bad = (pair_on[2] & pair_on[1]) | (pair_on[2] & pair_on[0]) | (pair_on[1] & pair_on[0]);
  assign s_legal = sin_bad ? 6'b000000 : Sin;
  assign busy    = (state == BREAK);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      gate    <= '0;
      target  <= '0;
      cnt     <= '0;
      fault   <= 1'b0;
      illegal <= 1'b0;
    end else begin
      state   <= state_nxt;
      gate    <= gate_nxt;
      target  <= target_nxt;
      cnt     <= cnt_nxt;
      fault   <= fault_nxt;
      illegal <= illegal_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    gate_nxt    = gate;
    target_nxt  = target;
    cnt_nxt     = cnt;
    fault_nxt   = fault;
    illegal_nxt = illegal;

    if (Short) begin
      state_nxt  = FAULT;
      gate_nxt   = '0;
      target_nxt = '0;
      fault_nxt  = 1'b1;
    end else if (state == FAULT) begin
      if (clr_fault) begin
        state_nxt   = IDLE;
        gate_nxt    = '0;
        target_nxt  = '0;
        fault_nxt   = 1'b0;
        illegal_nxt = 1'b0;
      end
    end else begin
      illegal_nxt = clr_fault ? 1'b0 : (illegal | sin_bad);
      if (s_legal != target) begin
        // Any change of request drops removed bits now and (re)starts the gap if bits must rise.
        target_nxt = s_legal;
        if (state == IDLE && (s_legal & ~gate) == 6'b000000) begin
          gate_nxt = s_legal;
        end else begin
          gate_nxt  = gate & s_legal;
          cnt_nxt   = CNT_LOAD;
          state_nxt = BREAK;
        end
      end else if (state == BREAK) begin
        if (cnt == 8'd0) begin
          gate_nxt  = target;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_switch_deadtime.sv
// Self-checking bench for switch_deadtime: vector table plus hand sequences, expected results via a queue.
module tb_switch_deadtime;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] Sin = '0;
  logic       Short = 1'b0;
  logic       clr_fault = 1'b0;
  logic [5:0] gate, gate1;
  logic       busy, fault, illegal, busy1, fault1, illegal1;

  switch_deadtime #(.DEADTIME(4)) dut (
    .clk(clk), .rst(rst), .Sin(Sin), .Short(Short), .clr_fault(clr_fault),
    .gate(gate), .busy(busy), .fault(fault), .illegal(illegal)
  );

  switch_deadtime #(.DEADTIME(1)) dut1 (
    .clk(clk), .rst(rst), .Sin(Sin), .Short(Short), .clr_fault(clr_fault),
    .gate(gate1), .busy(busy1), .fault(fault1), .illegal(illegal1)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0] g;
    logic       b;
    logic       f;
    logic       i;
  } exp_t;

  typedef struct {
    logic       r;
    logic [5:0] s;
    logic       sh;
    logic       cl;
    exp_t       e;
  } vec_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   step_no = 0;
  logic [5:0] prev_gate = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s step %0d: got 0x%0h, expected 0x%0h", name, step_no, act, req);
  endtask

  function automatic int pairs(input logic [5:0] g);
    return int'(|g[5:4]) + int'(|g[3:2]) + int'(|g[1:0]);
  endfunction

  task automatic step(input logic r, input logic [5:0] s, input logic sh, input logic cl,
                      input logic [5:0] eg, input logic eb, input logic ef, input logic ei);
    exp_t e, got;
    logic [5:0] rose, fell;
    rst = r; Sin = s; Short = sh; clr_fault = cl;
    e = '{g: eg, b: eb, f: ef, i: ei};
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    step_no++;
    e = exp_q.pop_front();
    got = '{g: gate, b: busy, f: fault, i: illegal};
    chk("gate/busy/fault/illegal", 32'(got), 32'(e));
    rose = gate & ~prev_gate;
    fell = ~gate & prev_gate;
    chk("no_rise_with_fall", 32'((rose != 6'b0) && (fell != 6'b0)), 32'd0);
    chk("single_pair", 32'(pairs(gate) > 1), 32'd0);
    prev_gate = gate;
  endtask

  task automatic add(input logic r, input logic [5:0] s, input logic sh, input logic cl,
                     input logic [5:0] eg, input logic eb, input logic ef, input logic ei);
    vec_t v;
    v.r = r; v.s = s; v.sh = sh; v.cl = cl;
    v.e = '{g: eg, b: eb, f: ef, i: ei};
    vecs.push_back(v);
  endtask

  initial begin
    //   rst  Sin        Sh    Cl    gate       busy  fault illegal
    add(1'b1, 6'b000000, 1'b0, 1'b0, 6'b000000, 1'b0, 1'b0, 1'b0); // reset state
    add(1'b1, 6'b110000, 1'b0, 1'b0, 6'b000000, 1'b0, 1'b0, 1'b0); // rst overrides request
    add(1'b0, 6'b110000, 1'b0, 1'b0, 6'b000000, 1'b1, 1'b0, 1'b0); // E0
    add(1'b0, 6'b110000, 1'b0, 1'b0, 6'b000000, 1'b1, 1'b0, 1'b0);
    add(1'b0, 6'b110000, 1'b0, 1'b0, 6'b000000, 1'b1, 1'b0, 1'b0);
    add(1'b0, 6'b110000, 1'b0, 1'b0, 6'b000000, 1'b1, 1'b0, 1'b0);
    add(1'b0, 6'b110000, 1'b0, 1'b0, 6'b110000, 1'b0, 1'b0, 1'b0); // E4
    add(1'b0, 6'b110000, 1'b0, 1'b0, 6'b110000, 1'b0, 1'b0, 1'b0);
    add(1'b0, 6'b001100, 1'b0, 1'b0, 6'b000000, 1'b1, 1'b0, 1'b0); // AA drops at once
    add(1'b0, 6'b001100, 1'b0, 1'b0, 6'b000000, 1'b1, 1'b0, 1'b0);
    add(1'b0, 6'b001100, 1'b0, 1'b0, 6'b000000, 1'b1, 1'b0, 1'b0);
    add(1'b0, 6'b001100, 1'b0, 1'b0, 6'b000000, 1'b1, 1'b0, 1'b0);
    add(1'b0, 6'b001100, 1'b0, 1'b0, 6'b001100, 1'b0, 1'b0, 1'b0);
    add(1'b0, 6'b000000, 1'b0, 1'b0, 6'b000000, 1'b0, 1'b0, 1'b0); // turn-off only
    add(1'b0, 6'b000000, 1'b0, 1'b0, 6'b000000, 1'b0, 1'b0, 1'b0);

    foreach (vecs[k]) begin
      step(vecs[k].r, vecs[k].s, vecs[k].sh, vecs[k].cl,
           vecs[k].e.g, vecs[k].e.b, vecs[k].e.f, vecs[k].e.i);
      // The DEADTIME=1 instance must finish its gap on the first edge after E0.
      if (k == 2) begin
        chk("dt1_gate_E0", 32'(gate1), 32'(6'b000000));
        chk("dt1_busy_E0", 32'(busy1), 32'd1);
      end
      if (k == 3) begin
        chk("dt1_gate_E1", 32'(gate1), 32'(6'b110000));
        chk("dt1_busy_E1", 32'(busy1), 32'd0);
      end
    end

    // Mid-gap request change at cnt=1 restarts a full gap.
    step(1'b0, 6'b110000, 1'b0, 1'b0, 6'b000000, 1'b1, 1'b0, 1'b0);
    step(1'b0, 6'b110000, 1'b0, 1'b0, 6'b000000, 1'b1, 1'b0, 1'b0);
    step(1'b0, 6'b110000, 1'b0, 1'b0, 6'b000000, 1'b1, 1'b0, 1'b0);
    step(1'b0, 6'b000011, 1'b0, 1'b0, 6'b000000, 1'b1, 1'b0, 1'b0);
    step(1'b0, 6'b000011, 1'b0, 1'b0, 6'b000000, 1'b1, 1'b0, 1'b0);
    step(1'b0, 6'b000011, 1'b0, 1'b0, 6'b000000, 1'b1, 1'b0, 1'b0);
    step(1'b0, 6'b000011, 1'b0, 1'b0, 6'b000000, 1'b1, 1'b0, 1'b0);
    step(1'b0, 6'b000011, 1'b0, 1'b0, 6'b000011, 1'b0, 1'b0, 1'b0);

    // Reach gate=110000, then a one-cycle Short.
    step(1'b0, 6'b110000, 1'b0, 1'b0, 6'b000000, 1'b1, 1'b0, 1'b0);
    step(1'b0, 6'b110000, 1'b0, 1'b0, 6'b000000, 1'b1, 1'b0, 1'b0);
    step(1'b0, 6'b110000, 1'b0, 1'b0, 6'b000000, 1'b1, 1'b0, 1'b0);
    step(1'b0, 6'b110000, 1'b0, 1'b0, 6'b000000, 1'b1, 1'b0, 1'b0);
    step(1'b0, 6'b110000, 1'b0, 1'b0, 6'b110000, 1'b0, 1'b0, 1'b0);
    step(1'b0, 6'b110000, 1'b1, 1'b0, 6'b000000, 1'b0, 1'b1, 1'b0);
    step(1'b0, 6'b110011, 1'b0, 1'b0, 6'b000000, 1'b0, 1'b1, 1'b0); // Sin ignored in FAULT
    step(1'b0, 6'b000011, 1'b1, 1'b1, 6'b000000, 1'b0, 1'b1, 1'b0); // Short beats clr_fault
    step(1'b0, 6'b000011, 1'b0, 1'b1, 6'b000000, 1'b0, 1'b0, 1'b0);
    step(1'b0, 6'b000011, 1'b0, 1'b0, 6'b000000, 1'b1, 1'b0, 1'b0);
    step(1'b0, 6'b000011, 1'b0, 1'b0, 6'b000000, 1'b1, 1'b0, 1'b0);
    step(1'b0, 6'b000011, 1'b0, 1'b0, 6'b000000, 1'b1, 1'b0, 1'b0);
    step(1'b0, 6'b000011, 1'b0, 1'b0, 6'b000000, 1'b1, 1'b0, 1'b0);
    step(1'b0, 6'b000011, 1'b0, 1'b0, 6'b000011, 1'b0, 1'b0, 1'b0);

    // Illegal pattern: treated as all-off, flag sticks until clr_fault.
    step(1'b0, 6'b110011, 1'b0, 1'b0, 6'b000000, 1'b0, 1'b0, 1'b1);
    step(1'b0, 6'b001100, 1'b0, 1'b0, 6'b000000, 1'b1, 1'b0, 1'b1);
    step(1'b0, 6'b001100, 1'b0, 1'b0, 6'b000000, 1'b1, 1'b0, 1'b1);
    step(1'b0, 6'b001100, 1'b1, 1'b0, 6'b000000, 1'b0, 1'b1, 1'b1); // Short mid-BREAK
    step(1'b0, 6'b001100, 1'b0, 1'b1, 6'b000000, 1'b0, 1'b0, 1'b0);

    // Reset mid-BREAK leaves no pending turn-on.
    step(1'b0, 6'b110000, 1'b0, 1'b0, 6'b000000, 1'b1, 1'b0, 1'b0);
    step(1'b1, 6'b110000, 1'b0, 1'b0, 6'b000000, 1'b0, 1'b0, 1'b0);
    step(1'b0, 6'b000000, 1'b0, 1'b0, 6'b000000, 1'b0, 1'b0, 1'b0);
    step(1'b0, 6'b000000, 1'b0, 1'b0, 6'b000000, 1'b0, 1'b0, 1'b0);
    step(1'b0, 6'b000000, 1'b0, 1'b0, 6'b000000, 1'b0, 1'b0, 1'b0);
    step(1'b0, 6'b000000, 1'b0, 1'b0, 6'b000000, 1'b0, 1'b0, 1'b0);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
